// File: rtl/i2c_cmd_seq.sv
// i2c_cmd_seq: checks an I2C command, launches the byte master, retries on NACK and returns one response.
// Latency: accept -> CHECK next cycle; bad command responds 2 cycles after accept, good ones on done/timeout.
// Backpressure: o_cmd_ready only in IDLE; RESP holds o_rsp_valid and all rsp fields until i_rsp_ready.
// Ports:
//   i_clk/i_rst           clock, synchronous active-high reset
//   i_cmd_* / o_cmd_ready command handshake (write buffer left-aligned)
//   o_rsp_* / i_rsp_ready response handshake (read data right-aligned), o_err_cnt failed-command count
//   o_i2cm_* / i_i2cm_*   registered command and launch pulse to the master, master status back
module i2c_cmd_seq #(
  parameter int WR_BYTE_WIDTH = 3,
  parameter int WR_BUF_WIDTH  = 32,
  parameter int RD_BYTE_WIDTH = 1,
  parameter int RD_BUF_WIDTH  = 8,
  parameter int DO_HOLD_CYC   = 5,
  parameter int MAX_RETRY     = 2,
  parameter int BACKOFF_CYC   = 64,
  parameter int TIMEOUT_CYC   = 200000
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_cmd_valid,
  output logic                     o_cmd_ready,
  input  logic [WR_BUF_WIDTH-1:0]  i_cmd_wr_buf,
  input  logic [WR_BYTE_WIDTH-1:0] i_cmd_wr_byte,
  input  logic [RD_BYTE_WIDTH-1:0] i_cmd_rd_byte,
  input  logic [3:0]               i_cmd_restart_byte,
  input  logic [31:0]              i_cmd_T_clk_num,
  output logic                     o_rsp_valid,
  input  logic                     i_rsp_ready,
  output logic [RD_BUF_WIDTH-1:0]  o_rsp_rd_data,
  output logic                     o_rsp_ack_err,
  output logic                     o_rsp_timeout,
  output logic                     o_rsp_bad_cmd,
  output logic [1:0]               o_rsp_retries,
  output logic [15:0]              o_err_cnt,
  output logic                     o_i2cm_do,
  output logic [WR_BUF_WIDTH-1:0]  o_i2cm_wr_buf_Lalign,
  output logic [WR_BYTE_WIDTH-1:0] o_i2cm_wr_byte,
  output logic [RD_BYTE_WIDTH-1:0] o_i2cm_rd_byte,
  output logic [3:0]               o_i2cm_restart_byte,
  output logic [31:0]              o_i2cm_T_clk_num,
  input  logic                     i_i2cm_busy,
  input  logic                     i_i2cm_done,
  input  logic                     i_i2cm_ack_err,
  input  logic [RD_BUF_WIDTH-1:0]  i_i2cm_rd_buf_Ralign
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CHECK   = 3'd1;
  localparam logic [2:0] S_LAUNCH  = 3'd2;
  localparam logic [2:0] S_WAIT    = 3'd3;
  localparam logic [2:0] S_BACKOFF = 3'd4;
  localparam logic [2:0] S_RESP    = 3'd5;

  localparam int TO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam int CNT_MAX = (BACKOFF_CYC > DO_HOLD_CYC) ? BACKOFF_CYC : DO_HOLD_CYC;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int CMPW    = (WR_BYTE_WIDTH > 4) ? WR_BYTE_WIDTH : 4;

  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0]   HOLD_LAST = CW'(DO_HOLD_CYC - 1);
  localparam logic [CW-1:0]   BO_LAST   = CW'(BACKOFF_CYC - 1);
  localparam logic [1:0]      RETRY_MAX = 2'(MAX_RETRY);

  logic [2:0]               state_q, state_d;
  logic                     ready_q, ready_d;
  logic [CW-1:0]            cnt_q, cnt_d;        // launch hold / backoff length
  logic [TO_W-1:0]          tcnt_q, tcnt_d;      // cycles since the current launch
  logic [1:0]               retry_q, retry_d;
  logic [WR_BUF_WIDTH-1:0]  wr_buf_q, wr_buf_d;
  logic [WR_BYTE_WIDTH-1:0] wr_byte_q, wr_byte_d;
  logic [RD_BYTE_WIDTH-1:0] rd_byte_q, rd_byte_d;
  logic [3:0]               restart_q, restart_d;
  logic [31:0]              tclk_q, tclk_d;
  logic [RD_BUF_WIDTH-1:0]  rd_data_q, rd_data_d;
  logic                     ack_err_q, ack_err_d;
  logic                     timeout_q, timeout_d;
  logic                     bad_q, bad_d;
  logic [15:0]              err_cnt_q, err_cnt_d;
  logic                     err_evt;
  logic                     bad_cmd;

  // Busy is status only; sequencing keys off the done pulse.
  logic unused_busy;
  assign unused_busy = i_i2cm_busy;

  assign bad_cmd = ((wr_byte_q == '0) && (rd_byte_q == '0))
                || (CMPW'(restart_q) > CMPW'(wr_byte_q))
                || (tclk_q < 32'd4);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tcnt_d    = tcnt_q;
    retry_d   = retry_q;
    wr_buf_d  = wr_buf_q;
    wr_byte_d = wr_byte_q;
    rd_byte_d = rd_byte_q;
    restart_d = restart_q;
    tclk_d    = tclk_q;
    rd_data_d = rd_data_q;
    ack_err_d = ack_err_q;
    timeout_d = timeout_q;
    bad_d     = bad_q;
    err_evt   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_cmd_valid && ready_q) begin
          wr_buf_d  = i_cmd_wr_buf;
          wr_byte_d = i_cmd_wr_byte;
          rd_byte_d = i_cmd_rd_byte;
          restart_d = i_cmd_restart_byte;
          tclk_d    = i_cmd_T_clk_num;
          rd_data_d = '0;
          ack_err_d = 1'b0;
          timeout_d = 1'b0;
          bad_d     = 1'b0;
          retry_d   = 2'd0;
          state_d   = S_CHECK;
        end
      end
      S_CHECK: begin
        if (bad_cmd) begin
          bad_d   = 1'b1;
          err_evt = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d   = '0;
          tcnt_d  = '0;
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH, S_WAIT: begin
        tcnt_d = tcnt_q + TO_W'(1);
        if (state_q == S_LAUNCH) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == HOLD_LAST) state_d = S_WAIT;
        end
        // Done overrides both the hold count and a simultaneous timeout.
        if (i_i2cm_done) begin
          rd_data_d = i_i2cm_rd_buf_Ralign;
          ack_err_d = i_i2cm_ack_err;
          if (i_i2cm_ack_err && (retry_q < RETRY_MAX)) begin
            retry_d = retry_q + 2'd1;
            cnt_d   = '0;
            state_d = S_BACKOFF;
          end else begin
            err_evt = i_i2cm_ack_err;
            state_d = S_RESP;
          end
        end else if (tcnt_q == TO_LAST) begin
          timeout_d = 1'b1;
          ack_err_d = 1'b0;
          err_evt   = 1'b1;
          state_d   = S_RESP;
        end
      end
      S_BACKOFF: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == BO_LAST) begin
          cnt_d   = '0;
          tcnt_d  = '0;
          state_d = S_LAUNCH;
        end
      end
      S_RESP: begin
        if (i_rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    err_cnt_d = (err_evt && (err_cnt_q != 16'hFFFF)) ? err_cnt_q + 16'd1 : err_cnt_q;
    // Registered ready keeps it low on the cycle right after reset.
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      ready_q   <= 1'b0;
      cnt_q     <= '0;
      tcnt_q    <= '0;
      retry_q   <= 2'd0;
      wr_buf_q  <= '0;
      wr_byte_q <= '0;
      rd_byte_q <= '0;
      restart_q <= 4'd0;
      tclk_q    <= 32'd0;
      rd_data_q <= '0;
      ack_err_q <= 1'b0;
      timeout_q <= 1'b0;
      bad_q     <= 1'b0;
      err_cnt_q <= 16'd0;
    end else begin
      state_q   <= state_d;
      ready_q   <= ready_d;
      cnt_q     <= cnt_d;
      tcnt_q    <= tcnt_d;
      retry_q   <= retry_d;
      wr_buf_q  <= wr_buf_d;
      wr_byte_q <= wr_byte_d;
      rd_byte_q <= rd_byte_d;
      restart_q <= restart_d;
      tclk_q    <= tclk_d;
      rd_data_q <= rd_data_d;
      ack_err_q <= ack_err_d;
      timeout_q <= timeout_d;
      bad_q     <= bad_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign o_cmd_ready          = ready_q;
  assign o_rsp_valid          = (state_q == S_RESP);
  assign o_rsp_rd_data        = rd_data_q;
  assign o_rsp_ack_err        = ack_err_q;
  assign o_rsp_timeout        = timeout_q;
  assign o_rsp_bad_cmd        = bad_q;
  assign o_rsp_retries        = retry_q;
  assign o_err_cnt            = err_cnt_q;
  assign o_i2cm_do            = (state_q == S_LAUNCH);
  assign o_i2cm_wr_buf_Lalign = wr_buf_q;
  assign o_i2cm_wr_byte       = wr_byte_q;
  assign o_i2cm_rd_byte       = rd_byte_q;
  assign o_i2cm_restart_byte  = restart_q;
  assign o_i2cm_T_clk_num     = tclk_q;

endmodule

// File: tb/tb_i2c_cmd_seq.sv
// tb_i2c_cmd_seq: directed bench for i2c_cmd_seq with a simple I2C master model and a response scoreboard.
// Latency: responses are awaited with bounded loops; the DUT runs with a 1000-cycle timeout.
// Backpressure: the response side is consumed one cycle after valid, or held off for the stall step.
module tb_i2c_cmd_seq;

  localparam int TO = 1000;

  typedef struct packed {
    logic       ack;
    logic       to;
    logic       bad;
    logic [1:0] retries;
    logic [7:0] rd;
    logic [15:0] err;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_wr_buf = '0;
  logic [2:0]  cmd_wr_byte = '0;
  logic [0:0]  cmd_rd_byte = '0;
  logic [3:0]  cmd_restart = '0;
  logic [31:0] cmd_T = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [7:0]  rsp_rd_data;
  logic        rsp_ack_err, rsp_timeout, rsp_bad;
  logic [1:0]  rsp_retries;
  logic [15:0] err_cnt;
  logic        m_do;
  logic [31:0] m_wr_buf;
  logic [2:0]  m_wr_byte;
  logic [0:0]  m_rd_byte;
  logic [3:0]  m_restart;
  logic [31:0] m_T;
  logic        m_busy = 1'b0;
  logic        m_done;
  logic        m_ack = 1'b0;
  logic [7:0]  m_rd = '0;
  logic        mdl_done = 1'b0;
  logic        tb_done = 1'b0;

  assign m_done = mdl_done | tb_done;

  always #5 clk = ~clk;

  i2c_cmd_seq #(.TIMEOUT_CYC(TO)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
    .i_cmd_wr_buf(cmd_wr_buf), .i_cmd_wr_byte(cmd_wr_byte), .i_cmd_rd_byte(cmd_rd_byte),
    .i_cmd_restart_byte(cmd_restart), .i_cmd_T_clk_num(cmd_T),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_rd_data(rsp_rd_data),
    .o_rsp_ack_err(rsp_ack_err), .o_rsp_timeout(rsp_timeout), .o_rsp_bad_cmd(rsp_bad),
    .o_rsp_retries(rsp_retries), .o_err_cnt(err_cnt),
    .o_i2cm_do(m_do), .o_i2cm_wr_buf_Lalign(m_wr_buf), .o_i2cm_wr_byte(m_wr_byte),
    .o_i2cm_rd_byte(m_rd_byte), .o_i2cm_restart_byte(m_restart), .o_i2cm_T_clk_num(m_T),
    .i_i2cm_busy(m_busy), .i_i2cm_done(m_done), .i_i2cm_ack_err(m_ack),
    .i_i2cm_rd_buf_Ralign(m_rd)
  );

  int   errors = 0;
  int   checks = 0;
  rsp_t exp_q[$];
  int   exp_err = 0;
  int   acc_cyc = 0;
  int   rsp_cyc = 0;

  // Master model: answers each launch with one done pulse, mst_delay samples after do is first seen.
  bit         mst_en = 1'b0;
  int         mst_delay = 20;
  logic [7:0] mst_rd = '0;
  bit         plan_q[$];

  initial begin : master
    int cnt;
    bit active;
    cnt = 0;
    active = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      mdl_done = 1'b0;
      if (rst) begin
        active = 1'b0;
      end else begin
        if (m_do && !active && mst_en) begin
          active = 1'b1;
          cnt = 0;
        end
        if (active) begin
          cnt++;
          if (cnt == mst_delay) begin
            mdl_done = 1'b1;
            m_ack = (plan_q.size() > 0) ? plan_q.pop_front() : 1'b0;
            m_rd = mst_rd;
            active = 1'b0;
          end
        end
      end
    end
  end

  // Launch monitor: cycle stamps of do rising/falling and high-run lengths.
  int   cyc = 0;
  int   rise_q[$];
  int   fall_q[$];
  int   run_q[$];
  int   run = 0;
  logic do_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (m_do && !do_prev) rise_q.push_back(cyc);
    if (!m_do && do_prev) begin
      fall_q.push_back(cyc);
      run_q.push_back(run);
    end
    if (m_do) run <= do_prev ? run + 1 : 1;
    do_prev <= m_do;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic rsp_t snap();
    rsp_t s;
    s.ack = rsp_ack_err;
    s.to = rsp_timeout;
    s.bad = rsp_bad;
    s.retries = rsp_retries;
    s.rd = rsp_rd_data;
    s.err = err_cnt;
    return s;
  endfunction

  task automatic expect_rsp(input logic ack, input logic to, input logic bad,
                            input logic [1:0] retries, input logic [7:0] rd);
    rsp_t e;
    if ((ack || to || bad) && exp_err < 65535) exp_err++;
    e.ack = ack;
    e.to = to;
    e.bad = bad;
    e.retries = retries;
    e.rd = rd;
    e.err = 16'(exp_err);
    exp_q.push_back(e);
  endtask

  task automatic clear_mon();
    rise_q.delete();
    fall_q.delete();
    run_q.delete();
  endtask

  task automatic send(input logic [31:0] wb, input logic [2:0] wn, input logic rn,
                      input logic [3:0] rs, input logic [31:0] t);
    int n = 0;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("send_ready", 64'(cmd_ready), 64'd1);
    cmd_wr_buf = wb;
    cmd_wr_byte = wn;
    cmd_rd_byte = rn;
    cmd_restart = rs;
    cmd_T = t;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    acc_cyc = cyc;
  endtask

  // Waits for a response, optionally stalls it for 'hold' cycles, then compares and consumes it.
  task automatic get_rsp(input string tag, input int hold);
    int   n = 0;
    rsp_t s, e;
    bit   stable = 1'b1;
    while (!rsp_valid && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, 64'(rsp_valid), 64'd1);
    rsp_cyc = cyc;
    s = snap();
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!rsp_valid || snap() != s) stable = 1'b0;
    end
    if (hold > 0) check({tag, "_stable"}, 64'(stable), 64'd1);
    check({tag, "_queued"}, 64'(exp_q.size() > 0), 64'd1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check({tag, "_ack_err"}, 64'(rsp_ack_err), 64'(e.ack));
    check({tag, "_timeout"}, 64'(rsp_timeout), 64'(e.to));
    check({tag, "_bad_cmd"}, 64'(rsp_bad), 64'(e.bad));
    check({tag, "_retries"}, 64'(rsp_retries), 64'(e.retries));
    check({tag, "_rd_data"}, 64'(rsp_rd_data), 64'(e.rd));
    check({tag, "_err_cnt"}, 64'(err_cnt), 64'(e.err));
    if (rsp_valid) begin
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
    end
  endtask

  initial begin : main
    bit seen;
    repeat (2) @(negedge clk);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_do", 64'(m_do), 64'd0);
    check("rst_err_cnt", 64'(err_cnt), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_cmd_ready", 64'(cmd_ready), 64'd1);

    // A done pulse while idle must not produce anything.
    tb_done = 1'b1;
    @(negedge clk);
    tb_done = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_done_rsp", 64'(rsp_valid), 64'd0);
    check("idle_done_ready", 64'(cmd_ready), 64'd1);

    // Clean write with repeated start.
    mst_en = 1'b1;
    mst_delay = 20;
    mst_rd = 8'hA5;
    plan_q = '{1'b0};
    clear_mon();
    expect_rsp(1'b0, 1'b0, 1'b0, 2'd0, 8'hA5);
    send(32'h6E888103, 3'd4, 1'b0, 4'd2, 32'd500);
    @(negedge clk);
    check("fld_wr_buf", 64'(m_wr_buf), 64'h6E888103);
    check("fld_wr_byte", 64'(m_wr_byte), 64'd4);
    check("fld_restart", 64'(m_restart), 64'd2);
    check("fld_T", 64'(m_T), 64'd500);
    get_rsp("ok", 0);
    check("ok_launches", 64'(rise_q.size()), 64'd1);
    check("ok_do_len", 64'((run_q.size() > 0) ? run_q[0] : -1), 64'd5);

    // NACK on every attempt: two retries, then a failed response.
    plan_q = '{1'b1, 1'b1, 1'b1};
    clear_mon();
    expect_rsp(1'b1, 1'b0, 1'b0, 2'd2, 8'hA5);
    send(32'h6E888103, 3'd4, 1'b0, 4'd2, 32'd500);
    get_rsp("nack3", 0);
    check("nack3_launches", 64'(rise_q.size()), 64'd3);
    check("nack3_gap0", 64'((rise_q.size() > 1 && fall_q.size() > 0) ? (rise_q[1] - fall_q[0] >= 64) : 0), 64'd1);
    check("nack3_gap1", 64'((rise_q.size() > 2 && fall_q.size() > 1) ? (rise_q[2] - fall_q[1] >= 64) : 0), 64'd1);
    check("nack3_do_len", 64'((run_q.size() > 2) ? run_q[2] : -1), 64'd5);

    // NACK then ACK: recovered after one retry.
    mst_rd = 8'h3C;
    plan_q = '{1'b1, 1'b0};
    clear_mon();
    expect_rsp(1'b0, 1'b0, 1'b0, 2'd1, 8'h3C);
    send(32'h6E888103, 3'd4, 1'b0, 4'd2, 32'd500);
    get_rsp("nack1", 0);
    check("nack1_launches", 64'(rise_q.size()), 64'd2);

    // Master never answers: timeout exactly TO cycles after launch.
    mst_en = 1'b0;
    clear_mon();
    expect_rsp(1'b0, 1'b1, 1'b0, 2'd0, 8'h00);
    send(32'h6E888103, 3'd4, 1'b0, 4'd2, 32'd500);
    get_rsp("tmo", 0);
    check("tmo_latency", 64'((rise_q.size() > 0) ? rsp_cyc - rise_q[0] : -1), 64'(TO));

    // Bad commands: no bytes, restart past write count, SCL period too short.
    clear_mon();
    expect_rsp(1'b0, 1'b0, 1'b1, 2'd0, 8'h00);
    send(32'h6E888103, 3'd0, 1'b0, 4'd0, 32'd500);
    get_rsp("bad_empty", 0);
    check("bad_empty_fast", 64'(rsp_cyc - acc_cyc <= 2), 64'd1);
    expect_rsp(1'b0, 1'b0, 1'b1, 2'd0, 8'h00);
    send(32'h6E888103, 3'd4, 1'b0, 4'd5, 32'd500);
    get_rsp("bad_restart", 0);
    expect_rsp(1'b0, 1'b0, 1'b1, 2'd0, 8'h00);
    send(32'h6E888103, 3'd4, 1'b0, 4'd0, 32'd3);
    get_rsp("bad_T", 0);
    check("bad_no_do", 64'(rise_q.size()), 64'd0);

    // T=4 is legal; done arriving during the launch pulse ends it early.
    mst_en = 1'b1;
    mst_delay = 2;
    mst_rd = 8'h77;
    plan_q = '{1'b0};
    clear_mon();
    expect_rsp(1'b0, 1'b0, 1'b0, 2'd0, 8'h77);
    send(32'hAB000000, 3'd1, 1'b1, 4'd1, 32'd4);
    get_rsp("early", 0);
    check("early_do_len", 64'((run_q.size() > 0) ? run_q[0] : -1), 64'd2);

    // Response stalled by the consumer: must hold steady.
    mst_delay = 20;
    mst_rd = 8'h5A;
    plan_q = '{1'b1, 1'b0};
    expect_rsp(1'b0, 1'b0, 1'b0, 2'd1, 8'h5A);
    send(32'h12345678, 3'd4, 1'b1, 4'd0, 32'd100);
    get_rsp("stall", 40);

    // Reset while waiting for done: abort silently.
    mst_en = 1'b0;
    send(32'hCAFEF00D, 3'd4, 1'b0, 4'd0, 32'd500);
    repeat (20) @(negedge clk);
    check("abort_pre_do", 64'(m_do), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    check("abort_do", 64'(m_do), 64'd0);
    check("abort_rsp_valid", 64'(rsp_valid), 64'd0);
    check("abort_cmd_ready", 64'(cmd_ready), 64'd0);
    check("abort_rsp_fields", 64'(snap()), 64'd0);
    check("abort_wr_buf", 64'(m_wr_buf), 64'd0);
    check("abort_T", 64'(m_T), 64'd0);
    rst = 1'b0;
    seen = 1'b0;
    repeat (TO + 100) begin
      @(negedge clk);
      if (rsp_valid || m_do) seen = 1'b1;
    end
    check("abort_quiet", 64'(seen), 64'd0);
    check("abort_ready_back", 64'(cmd_ready), 64'd1);
    check("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
